fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Arbitrates the framebuffer memory's single write port between up to NREQ pixel producers (clear engine, square rasterizer, player rasterizer, overlay). Producers present signed screen coordinates and a 3-bit colour. The block grants whole primitives in round-robin order, clips off-screen pixels, and drives the memory write enable, address and data through one register stage. It sits between the draw engines and the framebuffer memory instance; read ports are untouched.

## Interface
- NREQ, 3: number of requesters (2..4).
- PX_WIDTH, 256: framebuffer width in pixels.
- PX_HEIGHT, 192: framebuffer height in pixels; PX_WIDTH*PX_HEIGHT <= 65536.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester pixel valid.
- last  in  NREQ  per-requester; marks the final pixel of a primitive.
- px_x  in  16*NREQ  signed x per requester, slice i = [16i+15:16i].
- px_y  in  16*NREQ  signed y per requester.
- px_c  in  3*NREQ  colour per requester.
- fb_lock  in  1  when high, no pixel is accepted (buffer swap / vsync window).
- gnt  out  NREQ  per-requester ready; a pixel transfers when req[i] & gnt[i].
- busy  out  1  high while a primitive owner is held.
- memw  out  1  framebuffer write enable.
- memaddr  out  16  framebuffer address = y*PX_WIDTH + x.
- memi  out  3  framebuffer write data.
- clip_cnt  out  16  count of accepted pixels discarded as off-screen, saturating.

## Operation
- States: IDLE (no owner) and OWN (owner index o held in a register). Round-robin pointer ptr in 0..NREQ-1.
- IDLE: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ. gnt[winner]=1 combinationally the same cycle, unless fb_lock=1. All other gnt bits are 0.
- In IDLE, if the winner's pixel transfers with last=0 -> OWN, o=winner. If it transfers with last=1 -> stay IDLE, ptr=winner+1 mod NREQ (single-pixel primitive).
- OWN: gnt[o] = !fb_lock; all other gnt bits are 0 regardless of their req. A transfer with last=1 -> IDLE, ptr=o+1 mod NREQ.
- An owner dropping req mid-primitive keeps ownership; no other requester is granted until its last pixel.
- fb_lock while in OWN: ownership and ptr are retained, gnt is held low, and the primitive resumes when the lock drops.
- Accepted pixel is in-bounds iff 0<=x<PX_WIDTH and 0<=y<PX_HEIGHT (signed compares).
  - In-bounds: next cycle memw=1, memaddr=y*PX_WIDTH+x (16-bit unsigned), memi=colour.
  - Out-of-bounds: next cycle memw=0, and clip_cnt increments, holding at 0xFFFF.
- With no transfer, next cycle memw=0. memaddr and memi hold their last values.
- busy = (state==OWN).

## Timing
- Reset: state=IDLE, ptr=0, memw=0, memaddr=0, memi=0, clip_cnt=0, busy=0.
- gnt is combinational from req, state, ptr and fb_lock; no combinational path from memory outputs.
- Write latency is exactly 1 cycle from the transfer edge to memw/memaddr/memi.
- Throughput is one pixel per cycle, including back-to-back primitives from different requesters (no dead cycle between last and the next grant).
- Reset asserted mid-primitive: ownership is dropped, and the pipeline write pending in that cycle is suppressed (memw=0 the cycle after reset).
- Simultaneous last transfer and new requests: the grant update takes effect the following cycle using the updated ptr.

## Test plan
- Single requester 0 streams 4 pixels (0,0),(1,0),(2,0),(3,0), colour 5, last on the 4th -> memw high for 4 consecutive cycles one cycle later, memaddr 0,1,2,3, memi=5.
- All three requesters hold req with 2-pixel primitives -> grant order 0,1,2,0, with ptr advancing only on last; no interleaving inside a primitive.
- Requester 1 owns the port and drops req for 3 cycles while requester 2 requests -> gnt[2] stays 0 and the primitive completes from requester 1 first.
- Pixels at (-1,5), (PX_WIDTH,0), (0,PX_HEIGHT) and (PX_WIDTH-1,PX_HEIGHT-1) -> three clipped (clip_cnt=3, memw=0); the last is written at 0xBFFF with the defaults.
- fb_lock raised for 5 cycles mid-primitive -> gnt low, memw low, busy held at 1; the stream resumes with the same owner.
- rst pulsed mid-primitive with a transfer in that cycle -> next cycle memw=0, busy=0, ptr=0; requester 0 wins the next arbitration.

Source files
------------

// File: rtl/fb_wr_if.sv
// Producer-side pixel handshake and framebuffer write-port bundle for fb_write_arbiter.
// The slave modport is the arbiter; the master modport is the draw-engine/memory side.
interface fb_wr_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      last;
  logic [16*NREQ-1:0]   px_x;
  logic [16*NREQ-1:0]   px_y;
  logic [3*NREQ-1:0]    px_c;
  logic                 fb_lock;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 memw;
  logic [15:0]          memaddr;
  logic [2:0]           memi;
  logic [15:0]          clip_cnt;

  modport master (
    output req, last, px_x, px_y, px_c, fb_lock,
    input  gnt, busy, memw, memaddr, memi, clip_cnt
  );

  modport slave (
    input  req, last, px_x, px_y, px_c, fb_lock,
    output gnt, busy, memw, memaddr, memi, clip_cnt
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin, primitive-granular arbiter for the framebuffer write port with
// off-screen clipping and a single registered write stage.
module fb_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int PX_WIDTH  = 256,
  parameter int PX_HEIGHT = 192
) (
  input  logic    clk,
  input  logic    rst,
  fb_wr_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   winner;
  logic            found;
  logic [IW-1:0]   sel;
  logic            grant_en;
  logic [NREQ-1:0] gnt_c;
  logic            xfer;
  logic            px_last;
  logic signed [15:0] x_p0;
  logic signed [15:0] y_p0;
  logic [2:0]      c_p0;
  logic            inb_p0;

  logic            vld_p1;
  logic [15:0]     addr_p1;
  logic [2:0]      colour_p1;
  logic [15:0]     clip_cnt_r;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic in_bounds(input logic signed [15:0] x, input logic signed [15:0] y);
    return (x >= 0) && (int'(x) < PX_WIDTH) && (y >= 0) && (int'(y) < PX_HEIGHT);
  endfunction

  function automatic logic [15:0] pix_addr(input logic signed [15:0] x, input logic signed [15:0] y);
    int a;
    a = int'(y) * PX_WIDTH + int'(x);
    return 16'(a);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: round-robin winner search, grant, transfer and clip decision
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[wrap_add(ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    sel         = (state == OWN) ? owner : winner;
    grant_en    = !bus.fb_lock && ((state == OWN) || found);
    gnt_c       = '0;
    gnt_c[sel]  = grant_en;
    xfer        = grant_en && bus.req[sel];
    px_last     = bus.last[sel];
    x_p0        = $signed(bus.px_x[16*int'(sel) +: 16]);
    y_p0        = $signed(bus.px_y[16*int'(sel) +: 16]);
    c_p0        = bus.px_c[3*int'(sel) +: 3];
    inb_p0      = in_bounds(x_p0, y_p0);
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (px_last) begin
            ptr_nxt = next_idx(sel);
          end else begin
            state_nxt = OWN;
            owner_nxt = sel;
          end
        end
      end
      OWN: begin
        if (xfer && px_last) begin
          state_nxt = IDLE;
          ptr_nxt   = next_idx(owner);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  // Stage p1: registered write port; address/data only move on a real write
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      colour_p1  <= '0;
      clip_cnt_r <= '0;
    end else begin
      vld_p1 <= xfer && inb_p0;
      if (xfer && inb_p0) begin
        addr_p1   <= pix_addr(x_p0, y_p0);
        colour_p1 <= c_p0;
      end
      if (xfer && !inb_p0) begin
        clip_cnt_r <= sat_inc(clip_cnt_r);
      end
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.busy     = (state == OWN);
  assign bus.memw     = vld_p1;
  assign bus.memaddr  = addr_p1;
  assign bus.memi     = colour_p1;
  assign bus.clip_cnt = clip_cnt_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter against a behavioural
// model of ownership, round-robin pointer, clipping and the write port.
module tb_fb_write_arbiter;
  localparam int NREQ = 3;
  localparam int PXW  = 256;
  localparam int PXH  = 192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_wr_if #(.NREQ(NREQ)) bus();

  fb_write_arbiter #(.NREQ(NREQ), .PX_WIDTH(PXW), .PX_HEIGHT(PXH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // model state: owner index (-1 = none), pointer, expected write-port contents
  int          m_owner;
  int          m_ptr;
  int          m_clip;
  bit          m_valid = 1'b0;
  bit          m_memw;
  bit          m_data_chk;
  logic [15:0] m_addr;
  logic [2:0]  m_memi;
  int          rem[NREQ];
  int          xfers[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (bus.fb_lock) return g;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[(m_ptr + k) % NREQ]) begin
        g[(m_ptr + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic set_px(input int i, input int x, input int y, input int c);
    bus.px_x[16*i +: 16] = 16'(x);
    bus.px_y[16*i +: 16] = 16'(y);
    bus.px_c[3*i +: 3]   = 3'(c);
  endtask

  // Check current outputs, advance the model across one clock edge.
  task automatic step(output int xi);
    logic [NREQ-1:0] g;
    int x, y;
    xi = -1;
    #1;
    g = model_gnt();
    if (m_valid) begin
      chk("gnt", 32'(bus.gnt), 32'(g));
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("memw", 32'(bus.memw), 32'(m_memw));
      if (m_data_chk) begin
        chk("memaddr", 32'(bus.memaddr), 32'(m_addr));
        chk("memi", 32'(bus.memi), 32'(m_memi));
      end
      chk("clip_cnt", 32'(bus.clip_cnt), 32'(m_clip));
    end
    for (int i = 0; i < NREQ; i++) if (g[i] && bus.req[i]) xi = i;
    if (rst) begin
      xi = -1;
      m_owner = -1; m_ptr = 0; m_clip = 0;
      m_memw = 1'b0; m_addr = '0; m_memi = '0;
      m_data_chk = 1'b1; m_valid = 1'b1;
    end else begin
      m_memw = 1'b0;
      m_data_chk = 1'b0;
      if (xi >= 0) begin
        x = int'($signed(bus.px_x[16*xi +: 16]));
        y = int'($signed(bus.px_y[16*xi +: 16]));
        if (x >= 0 && x < PXW && y >= 0 && y < PXH) begin
          m_memw = 1'b1;
          m_data_chk = 1'b1;
          m_addr = 16'(y * PXW + x);
          m_memi = bus.px_c[3*xi +: 3];
        end else if (m_clip < 65535) begin
          m_clip++;
        end
        if (bus.last[xi]) begin
          m_owner = -1;
          m_ptr = (xi + 1) % NREQ;
        end else begin
          m_owner = xi;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    int xi;
    bus.req = '0; bus.last = '0; bus.fb_lock = 1'b0;
    rst = 1'b1;
    step(xi);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    xfers.delete();
  endtask

  // Producers with primitive lengths; last is raised on the final pixel.
  task automatic run_prod(input int n, input int req_pct, input int lock_pct,
                          input int rst_pm, input int fixed_len);
    int xi;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0) rem[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 5));
        bus.req[i]  = (int'($urandom_range(0, 99)) < req_pct);
        bus.last[i] = (rem[i] == 1);
        set_px(i, int'($urandom_range(0, PXW + 7)) - 4, int'($urandom_range(0, PXH + 7)) - 4,
               int'($urandom_range(0, 7)));
      end
      bus.fb_lock = (int'($urandom_range(0, 99)) < lock_pct);
      rst = (int'($urandom_range(0, 999)) < rst_pm);
      step(xi);
      if (rst) begin
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
      end else if (xi >= 0) begin
        rem[xi]--;
        xfers.push_back(xi);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    int xi;
    int exp_order[8];
    bus.req = '0; bus.last = '0; bus.fb_lock = 1'b0;
    bus.px_x = '0; bus.px_y = '0; bus.px_c = '0;
    do_reset();

    // single requester, four pixels on row 0, colour 5
    for (int p = 0; p < 4; p++) begin
      bus.req = 3'b001; bus.last = (p == 3) ? 3'b001 : 3'b000;
      set_px(0, p, 0, 5);
      step(xi);
      chk("t1_xfer", 32'(xi), 32'(0));
    end
    bus.req = '0; bus.last = '0;
    step(xi);

    // all requesters, 2-pixel primitives: order 0,0,1,1,2,2,0,0
    do_reset();
    run_prod(8, 100, 0, 0, 2);
    exp_order = '{0, 0, 1, 1, 2, 2, 0, 0};
    for (int k = 0; k < 8; k++) chk("t2_order", 32'(xfers[k]), 32'(exp_order[k]));

    // owner 1 drops req for 3 cycles while 2 waits
    do_reset();
    bus.req = 3'b010; bus.last = 3'b000; set_px(1, 10, 10, 1); set_px(2, 20, 20, 2);
    step(xi);
    chk("t3_own", 32'(xi), 32'(1));
    for (int k = 0; k < 3; k++) begin
      bus.req = 3'b100;
      step(xi);
      chk("t3_hold", 32'(xi), 32'(-1));
    end
    bus.req = 3'b110; bus.last = 3'b010;
    step(xi);
    chk("t3_fin", 32'(xi), 32'(1));
    bus.req = 3'b100; bus.last = 3'b100;
    step(xi);
    chk("t3_next", 32'(xi), 32'(2));
    bus.req = '0;
    step(xi);

    // clipping boundaries, then the bottom-right corner
    do_reset();
    bus.req = 3'b001; bus.last = 3'b001;
    set_px(0, -1, 5, 1);          step(xi);
    set_px(0, PXW, 0, 2);         step(xi);
    set_px(0, 0, PXH, 3);         step(xi);
    set_px(0, PXW - 1, PXH - 1, 6); step(xi);
    bus.req = '0;
    #1;
    chk("t4_clip", 32'(bus.clip_cnt), 32'(3));
    chk("t4_memw", 32'(bus.memw), 32'(1));
    chk("t4_addr", 32'(bus.memaddr), 32'h0000BFFF);
    step(xi);

    // fb_lock for 5 cycles mid-primitive
    do_reset();
    bus.req = 3'b011; bus.last = 3'b000; set_px(0, 4, 4, 3); set_px(1, 8, 8, 4);
    step(xi); step(xi);
    bus.fb_lock = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(xi);
      chk("t5_lock_busy", 32'(bus.busy), 32'(1));
    end
    bus.fb_lock = 1'b0;
    step(xi);
    chk("t5_resume", 32'(xi), 32'(0));
    bus.last = 3'b001;
    step(xi);
    bus.req = '0; bus.last = '0;
    step(xi);

    // reset mid-primitive with a transfer in the reset cycle
    do_reset();
    bus.req = 3'b010; bus.last = 3'b000; set_px(1, 1, 1, 7);
    step(xi);
    rst = 1'b1;
    step(xi);
    rst = 1'b0;
    bus.req = 3'b111;
    #1;
    chk("t6_memw", 32'(bus.memw), 32'(0));
    chk("t6_busy", 32'(bus.busy), 32'(0));
    chk("t6_win", 32'(bus.gnt), 32'(1));
    step(xi);
    bus.req = '0;
    step(xi);

    // long random run
    do_reset();
    run_prod(3000, 70, 8, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
